// File: rtl/dec_sequencer_pkg.sv
// Shared definitions for the decode sequencer: instruction-class codes, control-word
// bit positions, FSM encoding and the block-transfer control word builder.
package dec_defs;

   localparam logic [3:0] DEC_DP    = 4'd1;
   localparam logic [3:0] DEC_MUL   = 4'd2;
   localparam logic [3:0] DEC_SDT_A = 4'd6;
   localparam logic [3:0] DEC_SDT_B = 4'd8;
   localparam logic [3:0] DEC_BDT   = 4'd9;
   localparam logic [3:0] DEC_SWI   = 4'd10;

   localparam int CW_OP3_SEL      = 0;
   localparam int CW_R1_SEL       = 1;
   localparam int CW_R2_SEL       = 2;
   localparam int CW_R3_SEL       = 3;
   localparam int CW_INC_ORDER    = 4;
   localparam int CW_LOAD_MUL     = 5;
   localparam int CW_GCNT_IN_DEC  = 6;
   localparam int CW_DEST_ADD_VAL = 7;
   localparam int CW_DEST_SEL     = 8;
   localparam int CW_LEGACY_W     = 9;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   // Instruction bits the sequence depends on after accept.
   typedef struct packed {
      logic pre_idx;  // OPCODE[24]
      logic up;       // OPCODE[23]
      logic wb_acc;   // OPCODE[21]: writeback, or accumulate for MUL
      logic load;     // OPCODE[20]
   } op_flags_t;

   function automatic logic [CW_LEGACY_W-1:0] bdt_word(input logic load, input logic up,
                                                       input logic wb_step);
      logic [CW_LEGACY_W-1:0] w;
      w                  = '0;
      w[CW_DEST_SEL]     = 1'b1;
      w[CW_DEST_ADD_VAL] = load;
      w[CW_GCNT_IN_DEC]  = wb_step;
      w[CW_LOAD_MUL]     = 1'b1;
      w[CW_INC_ORDER]    = up;
      w[CW_R1_SEL]       = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/dec_sequencer_reglist_scan.sv
// Combinational LDM/STM register-list scanner: population count, lowest set
// register number and the list with that register removed.
module reglist_scan (
   input  logic [15:0] mask,
   output logic [4:0]  count,
   output logic [3:0]  low_idx,
   output logic [15:0] mask_rest
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count   = '0;
      low_idx = '0;
      // Descending walk: the last hit written is the lowest set bit.
      for (int i = 15; i >= 0; i--) begin
         count = count + 5'(mask[i]);
         if (mask[i]) low_idx = 4'(i);
      end
   end

   assign mask_rest = mask & (mask - 16'd1);

endmodule

// File: rtl/dec_sequencer.sv
// Multi-cycle decode sequencer: one control word per step for MUL/MLA, LDR/STR
// with writeback and LDM/STM lists. Optional abort input under DECSEQ_ABORT_EN.
module dec_sequencer
   import dec_defs::*;
#(
   parameter int CNT_W  = 9,
   parameter int STEP_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       OPCODE,
   input  logic [3:0]        Dec,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              stall,
`ifdef DECSEQ_ABORT_EN
   input  logic              abort,
`endif
   output logic [CNT_W-1:0]  CntOut,
   output logic              GCnt,
   output logic [STEP_W-1:0] step,
   output logic [3:0]        reg_idx,
   output logic              busy,
   output logic              last
);

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [3:0]          dec_q, dec_d;
   op_flags_t           flags_q, flags_d;
   logic [15:0]         mask_q, mask_d;
   logic                bdt_wb_q, bdt_wb_d;

   logic [4:0]          scan_count;
   logic [3:0]          scan_low;
   logic [15:0]         scan_rest;

   logic                busy_w, last_c, sdt_wb, abort_hit, accept;
   logic [CW_LEGACY_W-1:0] word_c;
   logic [3:0]          idx_c;

   reglist_scan u_scan (
      .mask      (mask_q),
      .count     (scan_count),
      .low_idx   (scan_low),
      .mask_rest (scan_rest)
   );

   assign busy_w = (state_q == S_RUN);
   assign sdt_wb = flags_q.wb_acc | !flags_q.pre_idx;

`ifdef DECSEQ_ABORT_EN
   assign abort_hit = abort & busy_w;
`else
   assign abort_hit = 1'b0;
`endif

   // Control word and final-step detect for the current step, forced to zero when idle.
   always_comb begin
      word_c = '0;
      idx_c  = '0;
      last_c = 1'b0;
      case (dec_q)
         DEC_DP: begin
            word_c = 9'h008;
            last_c = 1'b1;
         end
         DEC_MUL: begin
            if (flags_q.wb_acc) begin
               if (step_q == STEP_W'(0))      word_c = 9'h000;
               else if (step_q == STEP_W'(1)) word_c = 9'h008;
               else                           word_c = 9'h048;
               last_c = (step_q == STEP_W'(2));
            end else begin
               word_c = (step_q == STEP_W'(0)) ? 9'h008 : 9'h048;
               last_c = (step_q == STEP_W'(1));
            end
         end
         DEC_SDT_A, DEC_SDT_B: begin
            if (step_q == STEP_W'(0)) begin
               word_c = flags_q.load ? 9'h080 : {2'b00, !flags_q.pre_idx, 6'b000100};
               last_c = !sdt_wb;
            end else begin
               word_c = flags_q.load ? 9'h0C0 : 9'h004;
               last_c = 1'b1;
            end
         end
         DEC_BDT: begin
            if (mask_q != '0) begin
               word_c = bdt_word(flags_q.load, flags_q.up, 1'b0);
               idx_c  = scan_low;
               last_c = (scan_count == 5'd1) & !bdt_wb_q;
            end else begin
               word_c = bdt_wb_q ? bdt_word(flags_q.load, flags_q.up, 1'b1) : '0;
               last_c = 1'b1;
            end
         end
         DEC_SWI: begin
            word_c = 9'h001;
            last_c = 1'b1;
         end
         default: last_c = 1'b1;
      endcase
      if (!busy_w) begin
         word_c = '0;
         idx_c  = '0;
         last_c = 1'b0;
      end
   end

   assign op_ready = (!busy_w | (last_c & !stall)) & !abort_hit;
   assign accept   = op_valid & op_ready;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      dec_d    = dec_q;
      flags_d  = flags_q;
      mask_d   = mask_q;
      bdt_wb_d = bdt_wb_q;
      if (abort_hit) begin
         state_d = S_IDLE;
         step_d  = '0;
         mask_d  = '0;
      end else if (busy_w && stall) begin
         state_d = state_q;
      end else if (accept) begin
         state_d  = S_RUN;
         step_d   = '0;
         dec_d    = Dec;
         flags_d  = {OPCODE[24], OPCODE[23], OPCODE[21], OPCODE[20]};
         mask_d   = (Dec == DEC_BDT) ? OPCODE[15:0] : '0;
         bdt_wb_d = OPCODE[21] & (|OPCODE[15:0]);
      end else if (busy_w && last_c) begin
         state_d = S_IDLE;
         step_d  = '0;
         mask_d  = '0;
      end else if (busy_w) begin
         step_d = step_q + STEP_W'(1);
         mask_d = scan_rest;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         mask_q  <= mask_d;
      end
   end

   // NOTE: instruction payload is left unreset; every use is gated by busy or reloaded at accept.
   always_ff @(posedge clk) begin
      dec_q    <= dec_d;
      flags_q  <= flags_d;
      bdt_wb_q <= bdt_wb_d;
   end

   assign CntOut  = CNT_W'(word_c);
   assign GCnt    = busy_w & (step_q != '0);
   assign step    = step_q;
   assign reg_idx = idx_c;
   assign busy    = busy_w;
   assign last    = last_c;

endmodule

// File: tb/tb_dec_sequencer.sv
// Self-checking bench for dec_sequencer: expected control-word sequences are queued
// at issue time and popped as each step appears on the outputs.
module tb_dec_sequencer;

   localparam int CNT_W  = 9;
   localparam int STEP_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       OPCODE;
   logic [3:0]        Dec;
   logic              op_valid;
   logic              op_ready;
   logic              stall;
`ifdef DECSEQ_ABORT_EN
   logic              abort;
`endif
   logic [CNT_W-1:0]  CntOut;
   logic              GCnt;
   logic [STEP_W-1:0] step;
   logic [3:0]        reg_idx;
   logic              busy;
   logic              last;

   typedef struct {
      logic [4:0] step;
      logic [8:0] word;
      logic [3:0] idx;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_step   = 0;

   dec_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .OPCODE   (OPCODE),
      .Dec      (Dec),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .stall    (stall),
`ifdef DECSEQ_ABORT_EN
      .abort    (abort),
`endif
      .CntOut   (CntOut),
      .GCnt     (GCnt),
      .step     (step),
      .reg_idx  (reg_idx),
      .busy     (busy),
      .last     (last)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [8:0] word, input logic [3:0] idx, input logic lst);
      exp_t e;
      e.step = 5'(m_step);
      e.word = word;
      e.idx  = idx;
      e.last = lst;
      exp_q.push_back(e);
      m_step++;
   endtask

   // Reference sequence for one instruction, written from the class table.
   task automatic model(input logic [31:0] o, input logic [3:0] d);
      int   p;
      int   k;
      logic wb;
      m_step = 0;
      k      = 0;
      case (d)
         4'd1: push(9'h008, 4'd0, 1'b1);
         4'd2: begin
            if (o[21]) begin
               push(9'h000, 4'd0, 1'b0);
               push(9'h008, 4'd0, 1'b0);
               push(9'h048, 4'd0, 1'b1);
            end else begin
               push(9'h008, 4'd0, 1'b0);
               push(9'h048, 4'd0, 1'b1);
            end
         end
         4'd6, 4'd8: begin
            wb = o[21] | ~o[24];
            push(o[20] ? 9'h080 : (o[24] ? 9'h004 : 9'h044), 4'd0, !wb);
            if (wb) push(o[20] ? 9'h0C0 : 9'h004, 4'd0, 1'b1);
         end
         4'd9: begin
            p = $countones(o[15:0]);
            if (p == 0) begin
               push(9'h000, 4'd0, 1'b1);
            end else begin
               for (int i = 0; i < 16; i++) begin
                  if (o[i]) begin
                     k++;
                     push({1'b1, o[20], 1'b0, 1'b1, o[23], 4'b0010}, 4'(i), (k == p) && !o[21]);
                  end
               end
               if (o[21]) push({1'b1, o[20], 1'b1, 1'b1, o[23], 4'b0010}, 4'd0, 1'b1);
            end
         end
         4'd10:   push(9'h001, 4'd0, 1'b1);
         default: push(9'h000, 4'd0, 1'b1);
      endcase
   endtask

   task automatic compare_step();
      exp_t e;
      check("sb_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("busy",    32'(busy),    32'(1));
         check("step",    32'(step),    32'(e.step));
         check("CntOut",  32'(CntOut),  32'(e.word));
         check("GCnt",    32'(GCnt),    32'(e.step != 0));
         check("reg_idx", 32'(reg_idx), 32'(e.idx));
         check("last",    32'(last),    32'(e.last));
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},     32'(busy),     32'(0));
      check({tag, "_CntOut"},   32'(CntOut),   32'(0));
      check({tag, "_GCnt"},     32'(GCnt),     32'(0));
      check({tag, "_step"},     32'(step),     32'(0));
      check({tag, "_reg_idx"},  32'(reg_idx),  32'(0));
      check({tag, "_last"},     32'(last),     32'(0));
      check({tag, "_op_ready"}, 32'(op_ready), 32'(1));
   endtask

   task automatic issue(input logic [31:0] o, input logic [3:0] d);
      OPCODE   = o;
      Dec      = d;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         compare_step();
         tick();
      end
      check("drain_left", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic run_op(input logic [31:0] o, input logic [3:0] d);
      model(o, d);
      issue(o, d);
      drain();
      check_idle("post_op");
   endtask

   logic [31:0] t_op  [6] = '{32'hEF000000, 32'hE5B00000, 32'hE4800000,
                              32'hE8B00000, 32'hE1000090, 32'hE92D4010};
   logic [3:0]  t_dec [6] = '{4'd10, 4'd8, 4'd6, 4'd9, 4'd3, 4'd9};

   initial begin
      rst      = 1'b1;
      OPCODE   = '0;
      Dec      = '0;
      op_valid = 1'b0;
      stall    = 1'b0;
`ifdef DECSEQ_ABORT_EN
      abort    = 1'b0;
`endif
      tick();
      tick();
      check_idle("reset");
      rst = 1'b0;
      tick();
      check_idle("idle");

      // MLA: three steps with accumulate slot first.
      m_step = 0;
      push(9'h000, 4'd0, 1'b0);
      push(9'h008, 4'd0, 1'b0);
      push(9'h048, 4'd0, 1'b1);
      issue(32'hE0200091, 4'd2);
      drain();
      check_idle("mla_end");

      // LDMIA r0!, {r0,r1,r4,r15}: four transfers then writeback.
      m_step = 0;
      push(9'h1B2, 4'd0,  1'b0);
      push(9'h1B2, 4'd1,  1'b0);
      push(9'h1B2, 4'd4,  1'b0);
      push(9'h1B2, 4'd15, 1'b0);
      push(9'h1F2, 4'd0,  1'b1);
      issue(32'hE8B08013, 4'd9);
      drain();
      check_idle("ldm_end");

      // Reset held two cycles in the middle of an LDM.
      model(32'hE8B08013, 4'd9);
      issue(32'hE8B08013, 4'd9);
      compare_step();
      tick();
      compare_step();
      rst = 1'b1;
      tick();
      tick();
      check_idle("rst_mid");
      rst = 1'b0;
      exp_q.delete();
      tick();
      check_idle("rst_after");

      // STR pre-indexed without writeback, ADD accepted on its last step.
      model(32'hE5800000, 4'd6);
      OPCODE   = 32'hE5800000;
      Dec      = 4'd6;
      op_valid = 1'b1;
      tick();
      compare_step();
      check("str_last_ready", 32'(op_ready), 32'(1));
      model(32'hE0810002, 4'd1);
      OPCODE = 32'hE0810002;
      Dec    = 4'd1;
      tick();
      op_valid = 1'b0;
      compare_step();
      tick();
      check_idle("b2b_end");

      // MUL stalled three cycles on its final step.
      model(32'hE0000091, 4'd2);
      issue(32'hE0000091, 4'd2);
      compare_step();
      tick();
      stall = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("stall_CntOut",   32'(CntOut),   32'h048);
         check("stall_step",     32'(step),     32'(1));
         check("stall_op_ready", 32'(op_ready), 32'(0));
         tick();
      end
      stall = 1'b0;
      #1;
      compare_step();
      check("unstall_ready", 32'(op_ready), 32'(1));
      tick();
      check_idle("mul_end");

      for (int i = 0; i < 6; i++) run_op(t_op[i], t_dec[i]);

`ifdef DECSEQ_ABORT_EN
      // Abort on step 2 of a 16-register STM; concurrent stall and op_valid ignored.
      model(32'hE880FFFF, 4'd9);
      issue(32'hE880FFFF, 4'd9);
      compare_step();
      tick();
      compare_step();
      tick();
      compare_step();
      abort    = 1'b1;
      stall    = 1'b1;
      OPCODE   = 32'hE0810002;
      Dec      = 4'd1;
      op_valid = 1'b1;
      tick();
      abort    = 1'b0;
      stall    = 1'b0;
      op_valid = 1'b0;
      #1;
      check_idle("abort");
      exp_q.delete();
      tick();
      check_idle("abort_after");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
